axis_throttled_sink: RTL and testbench

- Receiving end of the 16-bit AXI-Stream link that the stream-source benches drive.
- Drives tready with a pseudo-random, LFSR-gated backpressure pattern and buffers accepted beats in a small FIFO.
- Presents the buffered beats on a simple valid/ready read port and keeps a beat count and an XOR checksum for end-to-end checking.

---
 rtl/axis_sink_pkg.sv | 17 +
 rtl/axis_sink_fifo.sv | 61 ++++++
 rtl/axis_throttled_sink.sv | 88 ++++++++
 tb/tb_axis_throttled_sink.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_sink_pkg.sv
// -----------------------------------------------------------------------------
// axis_sink_pkg
// Shared constants and the LFSR step function for the throttled AXI-Stream
// sink. The bench model uses lfsr_next as well, so both agree on the sequence.
// -----------------------------------------------------------------------------
package axis_sink_pkg;

   // Galois taps for the 32-bit right-shifting backpressure LFSR
   localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;
   localparam int unsigned DEFAULT_DATA_W = 16;

   // One step of the right-shifting Galois LFSR
   function automatic logic [31:0] lfsr_next(input logic [31:0] lfsr);
      return lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);
   endfunction

endpackage

// File: rtl/axis_sink_fifo.sv
// -----------------------------------------------------------------------------
// axis_sink_fifo
// Synchronous capture FIFO. DEPTH must be a power of 2 and at least 2, so
// the pointers wrap naturally. The head reads as zero while the FIFO is empty.
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_push, i_push_data     write strobe and data (caller guarantees !full)
//   i_pop                   read strobe (caller guarantees !empty)
//   o_head_data             oldest entry, 0 when empty
//   o_full, o_empty         occupancy flags
// -----------------------------------------------------------------------------
module axis_sink_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_head_data,
   output logic              o_full,
   output logic              o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the pointers define what is valid
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_full      = (r_count == (AW+1)'(DEPTH));
   assign o_empty     = (r_count == '0);
   assign o_head_data = o_empty ? '0 : r_mem[r_rd_ptr];

   a_no_overflow:  assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_push && o_full));
   a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_pop && o_empty));

endmodule

// File: rtl/axis_throttled_sink.sv
// -----------------------------------------------------------------------------
// axis_throttled_sink
// AXI-Stream sink with LFSR-driven backpressure. Accepted beats are buffered
// in a small FIFO and offered on a valid/ready read port; a beat counter and
// an XOR checksum of accepted data support end-to-end checking.
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_cfg_throttle            1: LFSR gates tready, 0: gate forced open
//   i_s_tdata/i_s_tvalid      stream input
//   o_s_tready                stream ready (registers only, never uses tvalid)
//   o_m_data/o_m_valid        FIFO head and not-empty
//   i_m_ready                 reader consumes the head
//   o_beat_count              accepted beats, wraps at 2^32
//   o_checksum                XOR of all accepted data
// -----------------------------------------------------------------------------
module axis_throttled_sink
   import axis_sink_pkg::*;
#(
   parameter int unsigned DATA_W     = DEFAULT_DATA_W,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_cfg_throttle,
   input  logic [DATA_W-1:0] i_s_tdata,
   input  logic              i_s_tvalid,
   output logic              o_s_tready,
   output logic [DATA_W-1:0] o_m_data,
   output logic              o_m_valid,
   input  logic              i_m_ready,
   output logic [31:0]       o_beat_count,
   output logic [DATA_W-1:0] o_checksum
);

   // An all-zero LFSR would lock up, so a zero seed is replaced by 1
   localparam logic [31:0] SEED = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;

   logic [31:0]       r_lfsr;
   logic              r_gate;
   logic [31:0]       r_beat_count;
   logic [DATA_W-1:0] r_checksum;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign o_s_tready = r_gate && !w_full;
   assign w_push     = i_s_tvalid && o_s_tready;
   assign w_pop      = !w_empty && i_m_ready;
   assign o_m_valid  = !w_empty;

   assign o_beat_count = r_beat_count;
   assign o_checksum   = r_checksum;

   // LFSR free-runs out of reset regardless of traffic; the gate lags it by one cycle
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_lfsr       <= SEED;
         r_gate       <= 1'b0;
         r_beat_count <= '0;
         r_checksum   <= '0;
      end else begin
         r_lfsr <= lfsr_next(r_lfsr);
         r_gate <= i_cfg_throttle ? r_lfsr[0] : 1'b1;
         if (w_push) begin
            r_beat_count <= r_beat_count + 32'd1;
            r_checksum   <= r_checksum ^ i_s_tdata;
         end
      end
   end

   axis_sink_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (w_push),
      .i_push_data (i_s_tdata),
      .i_pop       (w_pop),
      .o_head_data (o_m_data),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

endmodule

// File: tb/tb_axis_throttled_sink.sv
// -----------------------------------------------------------------------------
// tb_axis_throttled_sink
// Directed stimulus plus a cycle model and scoreboard. Expected beats are
// queued when the model accepts them; the monitor pops and compares whenever
// the model says the DUT pops its head.
// -----------------------------------------------------------------------------
module tb_axis_throttled_sink;
   import axis_sink_pkg::*;

   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] SEED  = 32'h0000_0001;

   logic          clk          = 1'b0;
   logic          rst_n        = 1'b0;
   logic          cfg_throttle = 1'b0;
   logic [DW-1:0] s_tdata      = '0;
   logic          s_tvalid     = 1'b0;
   logic          m_ready      = 1'b0;
   logic          s_tready;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic [31:0]   beat_count;
   logic [DW-1:0] checksum;

   int n_chk  = 0;
   int n_pass = 0;

   logic [DW-1:0] exp_q[$];

   // Reference model state
   logic [31:0]   md_lfsr;
   logic          md_gate;
   int unsigned   md_occ;
   logic [31:0]   md_cnt;
   logic [DW-1:0] md_cks;
   logic          md_ok = 1'b0;
   int unsigned   n_pop = 0;

   axis_throttled_sink #(
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH),
      .LFSR_SEED  (SEED)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_cfg_throttle (cfg_throttle),
      .i_s_tdata      (s_tdata),
      .i_s_tvalid     (s_tvalid),
      .o_s_tready     (s_tready),
      .o_m_data       (m_data),
      .o_m_valid      (m_valid),
      .i_m_ready      (m_ready),
      .o_beat_count   (beat_count),
      .o_checksum     (checksum)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat and return just after the edge that accepts it
   task automatic send(input logic [DW-1:0] d);
      int n = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      @(negedge clk);
      while (!s_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_tready) begin
         n_chk++;
         $display("FAIL send_timeout: tready low for %0d cycles, expected acceptance", n);
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
   endtask

   // Monitor / model: runs mid-cycle, when inputs and outputs are both stable
   always @(negedge clk) begin : mon
      logic exp_rdy;
      logic acc;
      logic pop;
      exp_rdy = 1'b0;
      if (md_ok) begin
         exp_rdy = md_gate && (md_occ < DEPTH);
         check("s_tready", 32'(s_tready), 32'(exp_rdy));
         check("m_valid", 32'(m_valid), 32'(md_occ != 0));
         check("beat_count", beat_count, md_cnt);
         check("checksum", 32'(checksum), 32'(md_cks));
         if (md_occ == 0) check("m_data_empty", 32'(m_data), 32'd0);
      end
      if (!rst_n) begin
         md_lfsr = SEED;
         md_gate = 1'b0;
         md_occ  = 0;
         md_cnt  = '0;
         md_cks  = '0;
         exp_q.delete();
         md_ok   = 1'b1;
      end else if (md_ok) begin
         acc = s_tvalid && exp_rdy;
         pop = (md_occ != 0) && m_ready;
         if (pop) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL sb_underflow: DUT popped %h, expected no entry", m_data);
            end else begin
               check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
            n_pop++;
         end
         if (acc) begin
            exp_q.push_back(s_tdata);
            md_cnt = md_cnt + 32'd1;
            md_cks = md_cks ^ s_tdata;
         end
         if (acc && !pop) md_occ++;
         else if (pop && !acc) md_occ--;
         md_gate = cfg_throttle ? md_lfsr[0] : 1'b1;
         md_lfsr = lfsr_next(md_lfsr);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at 1ms, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] ff_vec [4];
      logic [4:0]    gate_pat;
      int unsigned   p0;
      ff_vec   = '{16'h15B3, 16'h0001, 16'h00FF, 16'hA5A5};
      gate_pat = 5'b11011;

      // Reset with tvalid high: nothing may be accepted
      rst_n = 1'b0; s_tvalid = 1'b1; s_tdata = 16'h1234; m_ready = 1'b0; cfg_throttle = 1'b0;
      repeat (3) step();
      check("rst_tready", 32'(s_tready), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_beat_count", beat_count, 32'd0);
      check("rst_checksum", 32'(checksum), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);

      // Free flow
      s_tvalid = 1'b0; m_ready = 1'b1; rst_n = 1'b1;
      foreach (ff_vec[i]) send(ff_vec[i]);
      step();
      step();
      check("ff_beat_count", beat_count, 32'd4);
      check("ff_checksum", 32'(checksum), 32'h0000_B0E8);

      // Gate sequence from seed 1
      rst_n = 1'b0; cfg_throttle = 1'b1; m_ready = 1'b1; s_tvalid = 1'b0;
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("gate_seq", 32'(s_tready), 32'(gate_pat[4-k]));
      end
      repeat (1000) step();

      // Full backpressure
      rst_n = 1'b0; cfg_throttle = 1'b0; m_ready = 1'b0; s_tvalid = 1'b1;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_tdata = 16'h1000 + 16'(i);
         step();
      end
      check("full_beat_count", beat_count, 32'd4);
      check("full_tready", 32'(s_tready), 32'd0);
      check("full_m_valid", 32'(m_valid), 32'd1);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check("pop_reopens_tready", 32'(s_tready), 32'd1);
      check("pop_no_accept", beat_count, 32'd4);
      s_tdata = 16'h2000;
      step();
      check("refill_beat_count", beat_count, 32'd5);
      check("refill_tready", 32'(s_tready), 32'd0);
      s_tvalid = 1'b0;

      // Simultaneous push and pop at occupancy 2
      rst_n = 1'b0; m_ready = 1'b0;
      step();
      rst_n = 1'b1; s_tvalid = 1'b1;
      p0 = n_pop;
      for (int i = 0; i < 3; i++) begin
         s_tdata = 16'h3000 + 16'(i);
         step();
      end
      m_ready = 1'b1;
      for (int i = 3; i < 7; i++) begin
         s_tdata = 16'h3000 + 16'(i);
         step();
      end
      check("pp_occupancy", beat_count - 32'(n_pop - p0), 32'd2);
      check("pp_tready", 32'(s_tready), 32'd1);
      check("pp_m_valid", 32'(m_valid), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midrst_m_valid", 32'(m_valid), 32'd0);
      check("midrst_beat_count", beat_count, 32'd0);
      check("midrst_checksum", 32'(checksum), 32'd0);
      check("midrst_tready", 32'(s_tready), 32'd0);

      // Random soak: throttled first half, free gate second half
      cfg_throttle = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         if (i == 5000) cfg_throttle = 1'b0;
         s_tvalid = 1'($urandom_range(0, 1));
         m_ready  = 1'($urandom_range(0, 1));
         s_tdata  = 16'($urandom);
         step();
      end
      s_tvalid = 1'b0; m_ready = 1'b1;
      repeat (10) step();
      check("soak_drained", 32'(exp_q.size()), 32'd0);
      check("soak_m_valid", 32'(m_valid), 32'd0);
      check("soak_beat_count", beat_count, md_cnt);
      check("soak_checksum", 32'(checksum), 32'(md_cks));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
